// File: rtl/sipo_ctrl_pkg.sv
// Shared types and defaults for the start/stop framed serial receiver.
package sipo_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/sipo_shift_en.sv
// Serial-in/parallel-out shifter. Input enters at the MSB so the first bit received ends up at the LSB.
module sipo_shift_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr_i,
  input  logic             shift_en_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q <= '0;
    end else if (sclr_i) begin
      q_q <= '0;
    end else if (shift_en_i) begin
      q_q <= {din_i, q_q[WIDTH-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Start/stop frame receiver: FSM, bit counter, output word register and error flags.
// state | meaning
// IDLE  | waiting for a low start bit on a tick
// DATA  | shifting in WIDTH data bits
// STOP  | checking the stop bit, delivering or discarding the word
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_tick,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             sh_clr, sh_en, deliver, bad_stop;
  logic [WIDTH-1:0] sh_q;

  sipo_shift_en #(.WIDTH(WIDTH)) u_shift (
    .clk        (clk),
    .clr        (clr),
    .sclr_i     (sh_clr),
    .shift_en_i (sh_en),
    .din_i      (data_in),
    .q_o        (sh_q)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_clr   = 1'b0;
    sh_en    = 1'b0;
    deliver  = 1'b0;
    bad_stop = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bit_tick && !data_in) begin
            state_d = DATA;
            cnt_d   = '0;
            sh_clr  = 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            sh_en = 1'b1;
            // Counter parks at zero after the last bit so it never reaches WIDTH.
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_d = STOP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            state_d  = IDLE;
            deliver  = data_in;
            bad_stop = !data_in;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (deliver && (!out_valid_q || out_ready)) begin
      data_out_d  = sh_q;
      out_valid_d = 1'b1;
    end else if (deliver) begin
      overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // A set event in the same cycle wins over the clear.
    if (err_clr && !(deliver && out_valid_q && !out_ready)) begin
      overrun_d = 1'b0;
    end
    busy_d      = (state_d != IDLE);
    frame_err_d = bad_stop;
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: stimulus pushes expected words, a negedge monitor checks accepts.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       bit_tick = 1'b0;
  logic       data_in = 1'b1;
  logic [3:0] data_out;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .bit_tick  (bit_tick),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted word must match the next expected one.
  always @(negedge clk) begin
    if (!clr && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {28'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        check("word", {28'd0, data_out}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // One tick sampled on the next edge; returns 1 time unit after that edge.
  task automatic tick(input logic b);
    bit_tick = 1'b1;
    data_in  = b;
    @(posedge clk); #1;
    bit_tick = 1'b0;
    data_in  = 1'b1;
  endtask

  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      tick(w[i]);
      gap();
    end
  endtask

  task automatic send_frame(input logic [3:0] w);
    tick(1'b0); gap();
    send_data(w);
    tick(1'b1); gap();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {28'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    clr = 1'b0;
    en  = 1'b1;
    gap();

    // Good frame 4'hA with the consumer always ready.
    exp_q.push_back(4'hA);
    tick(1'b0);
    check("busy_rise", {31'd0, busy}, 32'd1);
    gap();
    send_data(4'hA);
    check("busy_data", {31'd0, busy}, 32'd1);
    tick(1'b1);
    check("a_valid", {31'd0, out_valid}, 32'd1);
    check("a_data", {28'd0, data_out}, 32'hA);
    check("a_busy_fall", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("a_valid_drop", {31'd0, out_valid}, 32'd0);
    check("a_no_ferr", {31'd0, frame_err}, 32'd0);
    gap();

    // Bad stop bit.
    tick(1'b0); gap();
    send_data(4'h3);
    tick(1'b0);
    check("ferr_pulse", {31'd0, frame_err}, 32'd1);
    check("ferr_valid", {31'd0, out_valid}, 32'd0);
    check("ferr_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("ferr_gone", {31'd0, frame_err}, 32'd0);
    gap();

    // Overrun: 3 held, 5 dropped; err_clr in the same cycle as the set loses.
    out_ready = 1'b0;
    exp_q.push_back(4'h3);
    send_frame(4'h3);
    check("hold_valid", {31'd0, out_valid}, 32'd1);
    tick(1'b0); gap();
    send_data(4'h5);
    err_clr = 1'b1;
    tick(1'b1);
    err_clr = 1'b0;
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_data_kept", {28'd0, data_out}, 32'h3);
    gap();
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("ovr_accept_drop", {31'd0, out_valid}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    gap();

    // Abort via en after two data bits, then a clean 4'hC.
    tick(1'b0); gap();
    tick(1'b1); gap();
    tick(1'b0); gap();
    en = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick(1'b0);
    check("abort_tick_ignored", {31'd0, busy}, 32'd0);
    en = 1'b1;
    gap();
    exp_q.push_back(4'hC);
    send_frame(4'hC);

    // clr mid-frame with a word pending.
    out_ready = 1'b0;
    send_frame(4'h6);
    check("pend_valid", {31'd0, out_valid}, 32'd1);
    tick(1'b0); gap();
    tick(1'b1);
    clr = 1'b1;
    #1;
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    check("clr_data", {28'd0, data_out}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    out_ready = 1'b1;
    gap();
    exp_q.push_back(4'hF);
    send_frame(4'hF);

    // Accept and new delivery on the same edge.
    out_ready = 1'b0;
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h6);
    send_frame(4'h9);
    tick(1'b0); gap();
    send_data(4'h6);
    out_ready = 1'b1;
    tick(1'b1);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_data", {28'd0, data_out}, 32'h6);
    check("b2b_no_ovr", {31'd0, overrun}, 32'd0);
    gap();
    check("b2b_drained", {31'd0, out_valid}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Frame controller that sequences a 4-bit-class serial-in/parallel-out shifter to receive start/stop-framed serial words. It detects a start bit, enables the shifter for exactly WIDTH bit periods, checks the stop bit, and presents the assembled word on a valid/ready output port with overrun and framing-error reporting. It sits between a raw serial line, qualified by an external bit-rate strobe, and any parallel consumer.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- CW, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-high reset
- en  in  1  receiver enable; low forces IDLE and aborts any frame in progress
- bit_tick  in  1  one-cycle strobe marking the sample point of each serial bit
- data_in  in  1  serial line, idle high; sampled only when bit_tick=1
- data_out  out  WIDTH  received word, LSB = first data bit; stable while out_valid=1
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- busy  out  1  high in DATA or STOP
- frame_err  out  1  one-cycle pulse on a bad stop bit
- overrun  out  1  sticky; a completed word was dropped because out_valid was held
- err_clr  in  1  synchronous clear of overrun

## Operation
- Reset values while clr=1: state=IDLE, bit counter=0, shifter=0, data_out=0, out_valid=0, busy=0, frame_err=0, overrun=0.
- FSM states: IDLE, DATA, STOP.
  - IDLE: on bit_tick && data_in==0 && en, the start bit is consumed → DATA, counter=0. Shifter is cleared on this edge.
  - DATA: on each bit_tick, the shifter shifts right with data_in entering at bit WIDTH-1, and the counter increments. On the tick where counter==WIDTH-1, the last data bit is shifted in → STOP.
  - STOP: on bit_tick, if data_in==1 the frame is good and the word is delivered, then → IDLE. If data_in==0, frame_err pulses for one cycle, the word is discarded, and → IDLE. No re-sync is attempted; the low line is treated as a new start bit only on a later tick.
- Delivery:
  - If out_valid==0, or out_ready==1 in the same cycle, data_out is loaded with the shifter and out_valid=1.
  - Otherwise the new word is dropped, overrun is set, and data_out keeps its old value.
- Handshake:
  - out_valid deasserts on the edge after an accept unless a new word is delivered on the same edge. Back-to-back delivery is legal.
  - data_out must not change while out_valid=1 and out_ready=0.
- en=0: state → IDLE and counter=0 on the next edge. out_valid and data_out are held; the pending word is still deliverable. overrun is unaffected.
- err_clr has lower priority than a set event. If an overrun occurs in the same cycle as err_clr, overrun stays 1.
- bit_tick with en=0 is ignored. Counter width is CW. The counter never exceeds WIDTH-1 and does not wrap.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: out_valid rises on the clock edge at the stop-bit tick.
- busy rises on the start-bit tick edge and falls on the stop-bit tick edge.
- frame_err is high for exactly the one cycle following the bad stop-bit tick edge.
- Minimum frame length is WIDTH+2 ticks. Ticks may be arbitrarily spaced, but at most one tick per cycle.
- Asserting clr asynchronously mid-frame discards the frame immediately. Deasserting clr is synchronized externally.

## Structure
- Package sipo_ctrl_pkg contains:
  - the state typedef (enum logic [1:0] {IDLE, DATA, STOP})
  - the default WIDTH constant
- Sub-module sipo_shift_en: WIDTH-bit SIPO shifter with synchronous clear and shift enable, async clr. Input enters at the MSB and shifts toward the LSB. The controller instantiates one copy and drives its clear and enable signals.
- All remaining logic lives in sipo_frame_ctrl: FSM, counter, output register, and flags.

## Test plan
- WIDTH=4, out_ready=1, frame 0|0,1,0,1|1 → data_out=4'hA, out_valid high 1 cycle, busy high 5 ticks, no flags.
- Frame 0|1,1,0,0|0 (bad stop) → frame_err one-cycle pulse, out_valid stays 0, FSM returns to IDLE.
- out_ready=0, frames 4'h3 then 4'h5 → data_out stays 4'h3, overrun=1. Then out_ready=1 → accept, out_valid drops. err_clr → overrun=0.
- en dropped after 2 data bits → IDLE, busy=0. A subsequent full frame 4'hC is received correctly.
- clr asserted mid-DATA with a word pending → all outputs reset to 0 immediately. Next frame 4'hF is received correctly.
- Accept and new delivery on the same edge (out_valid=1, out_ready=1 at stop tick) → data_out updates to the new word, out_valid stays 1, no overrun.
